// File: rtl/uart_tx_sched.sv
// Frame-level round-robin arbiter for the UART TX FIFO write port.
// A grant is held until the frame's last byte, or until the stall watchdog fires.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                                      PCLK,
  input  logic                                      PRESETn,
  input  logic                                      enable,
  input  logic [NREQ-1:0]                           req_valid,
  input  logic [NREQ*DW-1:0]                        req_data,
  input  logic [NREQ-1:0]                           req_last,
  output logic [NREQ-1:0]                           req_ready,
  input  logic                                      fifo_full,
  output logic                                      fifo_wr_en,
  output logic [DW-1:0]                             fifo_wr_data,
  output logic                                      grant_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                                      frame_done,
  output logic                                      timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  // state | meaning
  // IDLE  | no holder; arbitrate among valid requesters when enabled
  // XFER  | grant_id_q owns the FIFO write port until last byte or stall abort
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_err_q, timeout_err_d;

  logic [IW-1:0] winner;
  logic          found;
  int            idx;
  int            gidx;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          push;
  logic [IW-1:0] next_ptr;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    gidx      = int'(grant_id_q);
    g_valid   = req_valid[grant_id_q];
    g_last    = req_last[grant_id_q];
    g_data    = req_data[gidx*DW +: DW];
    req_ready = '0;
    if (state_q == XFER) req_ready[grant_id_q] = !fifo_full;
    push      = (state_q == XFER) && g_valid && !fifo_full;
    next_ptr  = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d     = XFER;
          grant_id_d  = winner;
          stall_cnt_d = '0;
        end
      end
      XFER: begin
        if (push) begin
          wr_data_d   = g_data;
          stall_cnt_d = '0;
          if (g_last) begin
            state_d      = IDLE;
            rr_ptr_d     = next_ptr;
            frame_done_d = 1'b1;
          end
        end else if (!g_valid) begin
          // Abort on the stalled cycle that takes the count to TIMEOUT-1.
          if (stall_cnt_q == CW'(TIMEOUT - 2)) begin
            state_d       = IDLE;
            rr_ptr_d      = next_ptr;
            stall_cnt_d   = '0;
            timeout_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant_valid  = (state_q == XFER);
  assign grant_id     = grant_id_q;
  assign fifo_wr_en   = push;
  assign fifo_wr_data = push ? g_data : wr_data_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;

endmodule
